// File: rtl/pipe_pkg.sv
// Shared definitions for the elastic pipeline stage registers.
// Config macro: PIPE_SKID_REG_STATS_EN (stall/bubble counters on pipe_skid_reg).
package pipe_pkg;

  // State encoded as {main_v, skid_v}: the bits are the occupancy flags themselves.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b10,
    TWO   = 2'b11
  } skid_state_t;

  // IF/ID payload: {PC[63:0], instr[31:0]}.
  localparam int IF_ID_W = 96;
  // ID/EX payload: {pc[63:0], rs1_val[63:0], rs2_val[63:0], imm[31:0], rd[4:0]}.
  localparam int ID_EX_W = 64 + 64 + 64 + 32 + 5;

  // RISC-V canonical NOP: addi x0, x0, 0.
  localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

  // Bubble payload for the IF/ID stage: zero PC, NOP instruction.
  function automatic logic [IF_ID_W-1:0] if_id_bubble();
    return {64'h0, NOP_INSTR};
  endfunction

endpackage

// File: rtl/pipe_skid_ctrl.sv
// Occupancy state machine for pipe_skid_reg. Produces registered in_ready /
// out_valid and the load strobes for the main and skid payload registers.
// Config macro: PIPE_SKID_REG_STATS_EN (not used here; see pipe_skid_reg).
module pipe_skid_ctrl
  import pipe_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic flush,
  input  logic in_valid,
  input  logic out_ready,
  output logic in_ready,
  output logic out_valid,
  output logic load_main_in,
  output logic load_main_skid,
  output logic load_skid
);

  skid_state_t state_q, state_d;
  logic        accept;
  logic        drain;

  // Both handshake outputs are bits of the state register, so neither has a
  // combinational path from any input.
  assign out_valid = state_q[1];
  assign in_ready  = ~state_q[0];

  assign accept = in_valid & in_ready;
  assign drain  = out_valid & out_ready;

  // Next-state and load-strobe decode; flush drops any same-cycle handshake.
  // NOTE: every output of this block gets a default first, so no path leaves
  // a signal unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    load_main_in   = 1'b0;
    load_main_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      unique case (state_q)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_d      = ONE;
          end
        end
        ONE: begin
          if (accept && drain) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid = 1'b1;
            state_d   = TWO;
          end else if (drain) begin
            state_d = EMPTY;
          end
        end
        TWO: begin
          if (drain) begin
            load_main_skid = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // State register with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of process ordering.
  always_ff @(posedge clk) begin
    if (reset) state_q <= EMPTY;
    else       state_q <= state_d;
  end

endmodule

// File: rtl/pipe_skid_reg.sv
// Elastic pipeline stage register: valid/ready handshake, two-entry skid
// buffer with registered in_ready, flush to bubble.
// Config macro: PIPE_SKID_REG_STATS_EN adds stall_cnt / bubble_cnt outputs.
module pipe_skid_reg
  import pipe_pkg::*;
#(
  parameter int               WIDTH  = IF_ID_W,
  parameter logic [WIDTH-1:0] BUBBLE = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
`ifdef PIPE_SKID_REG_STATS_EN
  ,
  output logic [31:0]      stall_cnt,
  output logic [31:0]      bubble_cnt
`endif
);

  logic             load_main_in;
  logic             load_main_skid;
  logic             load_skid;
  logic [WIDTH-1:0] main_q, main_d;
  logic [WIDTH-1:0] skid_q, skid_d;

  pipe_skid_ctrl u_ctrl (
    .clk            (clk),
    .reset          (reset),
    .flush          (flush),
    .in_valid       (in_valid),
    .out_ready      (out_ready),
    .in_ready       (in_ready),
    .out_valid      (out_valid),
    .load_main_in   (load_main_in),
    .load_main_skid (load_main_skid),
    .load_skid      (load_skid)
  );

  // Main always holds the older entry; it refills from skid when skid is occupied.
  assign out_data = main_q;

  // Payload muxes: flush loads the bubble, otherwise follow the control strobes.
  always_comb begin
    main_d = main_q;
    skid_d = skid_q;
    if (flush) begin
      main_d = BUBBLE;
      skid_d = BUBBLE;
    end else begin
      if (load_main_in)        main_d = in_data;
      else if (load_main_skid) main_d = skid_q;
      if (load_skid)           skid_d = in_data;
    end
  end

  // Payload registers.
  // NOTE: these wide data flops are reset deliberately: downstream stages see
  // a defined bubble on out_data straight out of reset, not just out_valid=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_q <= BUBBLE;
      skid_q <= BUBBLE;
    end else begin
      main_q <= main_d;
      skid_q <= skid_d;
    end
  end

`ifdef PIPE_SKID_REG_STATS_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;
  logic [31:0] bubble_cnt_q, bubble_cnt_d;

  // Occupancy statistics; wrap naturally, untouched by flush.
  always_comb begin
    stall_cnt_d  = stall_cnt_q + {31'b0, out_valid & ~out_ready};
    bubble_cnt_d = bubble_cnt_q + {31'b0, ~out_valid};
  end

  // Counter registers, cleared by reset only.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q  <= '0;
      bubble_cnt_q <= '0;
    end else begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
    end
  end

  assign stall_cnt  = stall_cnt_q;
  assign bubble_cnt = bubble_cnt_q;
`endif

endmodule
